stepper_motor_control_calc_mc: RTL

Multi-channel, handshaked successor to the single-axis acceleration calculator. It takes one request per axis (target position, current position/velocity, acceleration limits) and returns a signed acceleration command. The command decelerates so the axis stops at the target, using v_lim = (sqrt(a*(a+8*d)) - a)/2. One shared iterative multiply/sqrt datapath is time-multiplexed across up to NUM_CH axes, with valid/ready on both sides, a channel tag and a per-request stop mode.

---
 rtl/stepper_motor_control_calc_mc.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/stepper_motor_control_calc_mc.sv
`default_nettype none
// ============================================================================
// Module      : stepper_motor_control_calc_mc
// Description : Multi-channel acceleration command calculator for stepper
//               axes. Each accepted request (one axis) is processed on a
//               shared iterative datapath. The result is a signed
//               acceleration that brings the axis to rest at the target,
//               using the braking-limited velocity
//                   v_lim = (sqrt(a*(a+8*d)) - a) / 2.
//               Only one request is in flight at a time.
//
// Ports       : clk, reset      - clock, synchronous active-high reset
//               cke             - clock enable, freezes all state when low
//               s_ch            - channel tag of the request
//               s_target_x      - target position (signed)
//               s_cur_x         - current position (signed)
//               s_cur_v         - current velocity (signed)
//               s_max_a         - acceleration limit outside near zone
//               s_max_a_near    - acceleration limit inside near zone
//               s_stop          - brake to zero velocity, ignore position
//               s_valid/s_ready - request handshake
//               m_ch            - channel tag of the result
//               m_a             - signed acceleration command
//               m_near          - result was computed in the near zone
//               m_valid/m_ready - result handshake
//               busy            - a request is being processed
//
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_motor_control_calc_mc #(
    parameter int NUM_CH  = 4,
    parameter int X_WIDTH = 48,
    parameter int V_WIDTH = 16,
    parameter int A_WIDTH = 16,
    localparam int CH_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       cke,
    input  wire logic [CH_WIDTH-1:0]        s_ch,
    input  wire logic signed [X_WIDTH-1:0]  s_target_x,
    input  wire logic signed [X_WIDTH-1:0]  s_cur_x,
    input  wire logic signed [V_WIDTH:0]    s_cur_v,
    input  wire logic [A_WIDTH-1:0]         s_max_a,
    input  wire logic [A_WIDTH-1:0]         s_max_a_near,
    input  wire logic                       s_stop,
    input  wire logic                       s_valid,
    output logic                            s_ready,
    output logic [CH_WIDTH-1:0]             m_ch,
    output logic signed [A_WIDTH:0]         m_a,
    output logic                            m_near,
    output logic                            m_valid,
    input  wire logic                       m_ready,
    output logic                            busy
);

    localparam int D_WIDTH = 2 * V_WIDTH;
    localparam int L_WIDTH = (D_WIDTH + A_WIDTH + 1) / 2;
    localparam int P_WIDTH = D_WIDTH + A_WIDTH;
    // Radicand padded to an even width so the root loop consumes 2 bits/step
    localparam int R_WIDTH = 2 * L_WIDTH;
    // 8*dist + max_a without overflow before clipping
    localparam int E_WIDTH = X_WIDTH + 5;
    localparam int M_WIDTH = (L_WIDTH > A_WIDTH) ? L_WIDTH : A_WIDTH;
    // Final signed arithmetic width: holds tv (<= M_WIDTH bits) minus v_dir
    localparam int C_WIDTH = M_WIDTH + V_WIDTH + 4;
    localparam int N_WIDTH = $clog2(M_WIDTH) + 1;

    localparam logic [N_WIDTH-1:0] c_MUL_LAST  = N_WIDTH'(A_WIDTH - 1);
    localparam logic [N_WIDTH-1:0] c_SQRT_LAST = N_WIDTH'(L_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PREP = 3'd1;
    localparam logic [2:0] c_ST_CLIP = 3'd2;
    localparam logic [2:0] c_ST_MUL  = 3'd3;
    localparam logic [2:0] c_ST_SQRT = 3'd4;
    localparam logic [2:0] c_ST_CALC = 3'd5;
    localparam logic [2:0] c_ST_OUT  = 3'd6;

    logic [2:0]                 r_state;
    logic [N_WIDTH-1:0]         r_cnt;

    // Latched request
    logic [CH_WIDTH-1:0]        r_ch;
    logic signed [X_WIDTH-1:0]  r_target;
    logic signed [X_WIDTH-1:0]  r_cur;
    logic signed [V_WIDTH:0]    r_cur_v;
    logic [A_WIDTH-1:0]         r_max_a;
    logic [A_WIDTH-1:0]         r_max_a_near;
    logic                       r_stop;

    // Geometry of the move, normalised so "toward target" is positive
    logic [X_WIDTH:0]           r_dist;
    logic                       r_sign;
    logic signed [V_WIDTH+1:0]  r_v_dir;
    logic                       r_near;

    // Iterative datapath
    logic [D_WIDTH-1:0]         r_e;
    logic [P_WIDTH-1:0]         r_p;
    logic [A_WIDTH-1:0]         r_mplier;
    logic [R_WIDTH-1:0]         r_rad;
    logic [L_WIDTH+1:0]         r_rem;
    logic [L_WIDTH-1:0]         r_root;

    logic signed [X_WIDTH:0]    w_diff;
    logic                       w_sign;
    logic [X_WIDTH:0]           w_dist;
    logic signed [V_WIDTH+1:0]  w_v_ext;
    logic signed [V_WIDTH+1:0]  w_v_dir;
    logic                       w_near;
    logic [E_WIDTH-1:0]         w_e_sum;
    logic [D_WIDTH-1:0]         w_e;
    logic [P_WIDTH-1:0]         w_p_next;
    logic [L_WIDTH+3:0]         w_rem_sh;
    logic [L_WIDTH+3:0]         w_trial;
    logic                       w_take;
    logic signed [C_WIDTH-1:0]  w_root_c;
    logic signed [C_WIDTH-1:0]  w_max_a_c;
    logic signed [C_WIDTH-1:0]  w_lim_c;
    logic signed [C_WIDTH-1:0]  w_tv_c;
    logic signed [C_WIDTH-1:0]  w_vdir_c;
    logic signed [C_WIDTH-1:0]  w_a_c;
    logic signed [C_WIDTH-1:0]  w_amax_c;
    logic [A_WIDTH-1:0]         w_amax;
    logic signed [A_WIDTH:0]    w_clamp;
    logic signed [A_WIDTH:0]    w_out;

    assign s_ready = (r_state == c_ST_IDLE);
    assign busy    = (r_state != c_ST_IDLE);

    always_comb begin
        // Sign-extended difference is one bit wider, so |diff| never overflows
        w_diff    = {r_target[X_WIDTH-1], r_target} - {r_cur[X_WIDTH-1], r_cur};
        w_sign    = w_diff[X_WIDTH];
        w_dist    = w_sign ? -w_diff : w_diff;
        w_v_ext   = {r_cur_v[V_WIDTH], r_cur_v};
        w_v_dir   = w_sign ? -w_v_ext : w_v_ext;
        w_near    = (w_dist <= (X_WIDTH + 1)'(r_max_a));

        w_e_sum   = E_WIDTH'({r_dist, 3'b000}) + E_WIDTH'(r_max_a);
        w_e       = (w_e_sum > E_WIDTH'({D_WIDTH{1'b1}})) ? {D_WIDTH{1'b1}}
                                                          : w_e_sum[D_WIDTH-1:0];

        // MSB-first shift-add multiply
        w_p_next  = (r_p << 1) + (r_mplier[A_WIDTH-1] ? P_WIDTH'(r_e) : '0);

        // Restoring square root, two radicand bits per step
        w_rem_sh  = {r_rem, r_rad[R_WIDTH-1 -: 2]};
        w_trial   = (L_WIDTH + 4)'({r_root, 2'b01});
        w_take    = (w_rem_sh >= w_trial);

        w_root_c  = C_WIDTH'(r_root);
        w_max_a_c = C_WIDTH'(r_max_a);
        w_lim_c   = (w_root_c >= w_max_a_c) ? ((w_root_c - w_max_a_c) >>> 1) : '0;
        // In the near zone dist <= max_a, so its low A_WIDTH bits are exact
        w_tv_c    = r_stop ? '0 : (r_near ? C_WIDTH'(r_dist[A_WIDTH-1:0]) : w_lim_c);
        w_vdir_c  = C_WIDTH'(r_v_dir);
        w_a_c     = w_tv_c - w_vdir_c;

        w_amax    = r_near ? r_max_a_near : r_max_a;
        w_amax_c  = C_WIDTH'(w_amax);
        if (w_a_c > w_amax_c) begin
            w_clamp = {1'b0, w_amax};
        end else if (w_a_c < -w_amax_c) begin
            w_clamp = -{1'b0, w_amax};
        end else begin
            w_clamp = w_a_c[A_WIDTH:0];
        end
        // Back from "toward target" frame into absolute direction
        w_out     = r_sign ? -w_clamp : w_clamp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            m_valid <= 1'b0;
            m_a     <= '0;
            m_ch    <= '0;
            m_near  <= 1'b0;
        end else if (cke) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (s_valid) begin
                        r_ch         <= s_ch;
                        r_target     <= s_target_x;
                        r_cur        <= s_cur_x;
                        r_cur_v      <= s_cur_v;
                        r_max_a      <= s_max_a;
                        r_max_a_near <= s_max_a_near;
                        r_stop       <= s_stop;
                        r_state      <= c_ST_PREP;
                    end
                end
                c_ST_PREP: begin
                    r_dist  <= w_dist;
                    r_sign  <= w_sign;
                    r_v_dir <= w_v_dir;
                    r_near  <= w_near;
                    r_state <= c_ST_CLIP;
                end
                c_ST_CLIP: begin
                    r_e      <= w_e;
                    r_p      <= '0;
                    r_mplier <= r_max_a;
                    r_cnt    <= '0;
                    r_state  <= c_ST_MUL;
                end
                c_ST_MUL: begin
                    r_p      <= w_p_next;
                    r_mplier <= r_mplier << 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_MUL_LAST) begin
                        r_rad   <= R_WIDTH'(w_p_next);
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= '0;
                        r_state <= c_ST_SQRT;
                    end
                end
                c_ST_SQRT: begin
                    r_rad  <= r_rad << 2;
                    // The true remainder always fits L_WIDTH+2 bits
                    r_rem  <= w_take ? (w_rem_sh[L_WIDTH+1:0] - w_trial[L_WIDTH+1:0])
                                     : w_rem_sh[L_WIDTH+1:0];
                    r_root <= {r_root[L_WIDTH-2:0], w_take};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_SQRT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    m_a     <= w_out;
                    m_ch    <= r_ch;
                    m_near  <= r_near;
                    m_valid <= 1'b1;
                    r_state <= c_ST_OUT;
                end
                c_ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
